frame_rr_arbiter: RTL

- Frame-aware round-robin arbiter that merges WIDTH 32-bit word sources into one output stream.
- Once a channel is granted, it stays locked until its LAST-flagged word is transferred, so frames are never interleaved.
- Sits between per-channel FIFOs and the shared readout FIFO or transfer layer.
- Output is one registered pipeline stage with a valid/ready handshake. A stall timeout releases a channel whose frame stops delivering words.

---
 rtl/frame_rr_arbiter_pkg.sv | 42 ++++
 rtl/frame_rr_arbiter_pick.sv | 32 +++
 rtl/frame_rr_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/frame_rr_arbiter_pkg.sv
// Shared types and helpers for the frame-aware round-robin arbiter.
// Holds the arbiter state encoding, a constant-friendly clog2, and the
// one-hot to binary index conversion used for the optional source tag.
package frame_rr_arbiter_pkg;

    // Arbiter control states: IDLE arbitrates, LOCK streams one frame.
    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Width of one source word and of the source tag.
    localparam int WORD_W = 32;
    localparam int SRC_W  = 8;

    // Widest channel vector the index helper has to decode.
    localparam int MAX_CH = 16;

    // Ceiling log2, usable in parameter context.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        for (v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Binary index of the set bit of a one-hot vector (0 when empty).
    function automatic logic [SRC_W-1:0] onehot_to_index(input logic [MAX_CH-1:0] onehot);
        logic [SRC_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (onehot[i]) begin
                idx = SRC_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/frame_rr_arbiter_pick.sv
// Combinational round-robin picker.
// Returns the first requesting channel strictly above the one-hot previous
// winner, wrapping to channel 0. An all-zero prev behaves like the MSB, so
// the search then starts at channel 0. pick is zero when nothing requests.
module rr_onehot_pick #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] prev,
    output logic [WIDTH-1:0] pick
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] upper_mask;
    logic [WIDTH-1:0] upper_req;
    logic [WIDTH-1:0] search_req;

    // Isolate the lowest set bit of a vector.
    function automatic logic [WIDTH-1:0] lowest_set(input logic [WIDTH-1:0] v);
        return v & (~v + ONE);
    endfunction

    // Prefer requests above prev; if none, wrap around and take the lowest request.
    always_comb begin
        upper_mask = ~(prev | (prev - ONE));
        upper_req  = req & upper_mask;
        search_req = (|upper_req) ? upper_req : req;
        pick       = lowest_set(search_req);
    end

endmodule

// File: rtl/frame_rr_arbiter.sv
// Frame-aware round-robin arbiter: merges WIDTH 32-bit word sources into a
// single registered valid/ready stream without interleaving frames. A locked
// channel that stops requesting for TIMEOUT cycles is forcibly released.
// Optional feature: define FRAME_RR_ARB_SRC_TAG_EN to add SRC_OUT, the binary
// index of the channel that produced the current output word.
module frame_rr_arbiter
    import frame_rr_arbiter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [WIDTH-1:0]       WRITE_REQ,
    input  logic [WIDTH-1:0]       LAST_IN,
    input  logic [WIDTH*32-1:0]    DATA_IN,
    output logic [WIDTH-1:0]       READ_GRANT,
    input  logic                   READY_OUT,
    output logic                   WRITE_OUT,
    output logic [31:0]            DATA_OUT,
    output logic                   LAST_OUT,
    output logic                   BUSY,
    output logic                   TIMEOUT_ERR
`ifdef FRAME_RR_ARB_SRC_TAG_EN
    ,
    output logic [7:0]             SRC_OUT
`endif
);

    // Counter is one bit wider than needed to reach TIMEOUT-1 so it can saturate.
    localparam int                 CNT_W    = clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [WIDTH-1:0]   PREV_RST = {1'b1, {(WIDTH-1){1'b0}}};

    arb_state_e             state_q, state_d;
    logic [WIDTH-1:0]       sel_q, sel_d;
    logic [WIDTH-1:0]       prev_q, prev_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   write_out_q, write_out_d;
    logic [WORD_W-1:0]      data_out_q, data_out_d;
    logic                   last_out_q, last_out_d;
    logic                   timeout_err_q, timeout_err_d;

    logic [WIDTH-1:0]       pick;
    logic [WIDTH-1:0]       grant;
    logic                   granted;
    logic                   load_ok;
    logic [WORD_W-1:0]      sel_word;
    logic                   sel_last;
    logic                   sel_req;

`ifdef FRAME_RR_ARB_SRC_TAG_EN
    logic [SRC_W-1:0]       src_q, src_d;
    logic [MAX_CH-1:0]      sel_wide;

    assign sel_wide = MAX_CH'(sel_q);
`endif

    rr_onehot_pick #(
        .WIDTH (WIDTH)
    ) u_pick (
        .req  (WRITE_REQ),
        .prev (prev_q),
        .pick (pick)
    );

    // Route the locked channel's word, LAST flag and request to common signals.
    always_comb begin
        sel_word = '0;
        sel_last = 1'b0;
        sel_req  = 1'b0;
        for (int j = 0; j < WIDTH; j++) begin
            if (sel_q[j]) begin
                sel_word = sel_word | DATA_IN[j*32 +: 32];
                sel_last = sel_last | LAST_IN[j];
                sel_req  = sel_req | WRITE_REQ[j];
            end
        end
    end

    // Pop strobe: only the locked channel, only when the output register can take a word.
    always_comb begin
        load_ok = !write_out_q || READY_OUT;
        grant   = '0;
        if ((state_q == LOCK) && load_ok) begin
            grant = sel_q & WRITE_REQ;
        end
        granted = |grant;
    end

    assign READ_GRANT = grant;

    // Next-state, output-register and stall-counter logic.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        prev_d        = prev_q;
        cnt_d         = cnt_q;
        write_out_d   = write_out_q;
        data_out_d    = data_out_q;
        last_out_d    = last_out_q;
        timeout_err_d = 1'b0;
`ifdef FRAME_RR_ARB_SRC_TAG_EN
        src_d         = src_q;
`endif

        // Output register: load on a grant, drain when the held word was taken.
        if (granted) begin
            write_out_d = 1'b1;
            data_out_d  = sel_word;
            last_out_d  = sel_last;
`ifdef FRAME_RR_ARB_SRC_TAG_EN
            src_d       = onehot_to_index(sel_wide);
`endif
        end else if (load_ok) begin
            write_out_d = 1'b0;
            last_out_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (|WRITE_REQ) begin
                    sel_d   = pick;
                    prev_d  = pick;
                    cnt_d   = '0;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (granted) begin
                    // A LAST grant always wins over a timeout because it clears the counter.
                    cnt_d = '0;
                    if (sel_last) begin
                        state_d = IDLE;
                    end
                end else if (!sel_req) begin
                    // Only a silent source counts; downstream back-pressure does not.
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (cnt_q == CNT_LAST) begin
                        timeout_err_d = 1'b1;
                        state_d       = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; prev resets to the MSB so channel 0 wins first.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= IDLE;
            sel_q         <= '0;
            prev_q        <= PREV_RST;
            cnt_q         <= '0;
            write_out_q   <= 1'b0;
            data_out_q    <= '0;
            last_out_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            prev_q        <= prev_d;
            cnt_q         <= cnt_d;
            write_out_q   <= write_out_d;
            data_out_q    <= data_out_d;
            last_out_q    <= last_out_d;
            timeout_err_q <= timeout_err_d;
        end
    end

`ifdef FRAME_RR_ARB_SRC_TAG_EN
    // Source tag travels with the data word.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            src_q <= '0;
        end else begin
            src_q <= src_d;
        end
    end

    assign SRC_OUT = src_q;
`endif

    assign WRITE_OUT   = write_out_q;
    assign DATA_OUT    = data_out_q;
    assign LAST_OUT    = last_out_q;
    assign BUSY        = (state_q == LOCK);
    assign TIMEOUT_ERR = timeout_err_q;

endmodule
